// File: rtl/conv3x3_pkg.sv
// Types and constants shared by the 3x3 window sequencer and the window assembler.
package conv3x3_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int WIN_SLOTS = 9;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 640;

    // Fetch order of the sequencer: 0,1,2,W,W+1,W+2,2W,2W+1,2W+2
    localparam int SLOT_OFFSET [WIN_SLOTS] = '{
        0, 1, 2,
        IMG_W_DEF, IMG_W_DEF + 1, IMG_W_DEF + 2,
        2 * IMG_W_DEF, 2 * IMG_W_DEF + 1, 2 * IMG_W_DEF + 2
    };

    function automatic int slot_offset(input int slot, input int img_w);
        return (slot / 3) * img_w + (slot % 3);
    endfunction

endpackage

// File: rtl/conv3x3_window_assembler_if.sv
// Pixel-in / window-out handshake bundle of the 3x3 window assembler.
// out_sum is present only when CONV3X3_WINDOW_SUM_EN is defined.
interface conv3x3_window_assembler_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
);
    import conv3x3_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [3:0]                 in_idx;
    logic [PIX_W-1:0]           in_pix;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIN_SLOTS*PIX_W-1:0] out_win;
    logic [ADDR_W-1:0]          out_base_addr;
    logic                       out_last;
    logic                       err_seq;
`ifdef CONV3X3_WINDOW_SUM_EN
    logic [PIX_W+3:0]           out_sum;
`endif

    modport slave (
        input  in_valid, in_idx, in_pix, out_ready,
`ifdef CONV3X3_WINDOW_SUM_EN
        output out_sum,
`endif
        output in_ready, out_valid, out_win, out_base_addr, out_last, err_seq
    );

    modport master (
        output in_valid, in_idx, in_pix, out_ready,
`ifdef CONV3X3_WINDOW_SUM_EN
        input  out_sum,
`endif
        input  in_ready, out_valid, out_win, out_base_addr, out_last, err_seq
    );

endinterface

// File: rtl/conv3x3_pos_tracker.sv
// Top-left position of the current window (stride 1) with an incrementally kept
// base address and a registered final-window flag.
module conv3x3_pos_tracker #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              advance,
    output logic [ADDR_W-1:0] base_addr,
    output logic              last
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [ADDR_W-1:0] base_nxt;
    logic line_end, last_row;

    assign line_end = (col == COL_W'(IMG_W - 3));
    assign last_row = (row == ROW_W'(IMG_H - 3));

    // Line end jumps the base by 3: (row+1)*W = row*W + (W-3) + 3
    always_comb begin
        col_nxt  = col + COL_W'(1);
        row_nxt  = row;
        base_nxt = base_addr + ADDR_W'(1);
        if (line_end && last_row) begin
            col_nxt  = '0;
            row_nxt  = '0;
            base_nxt = '0;
        end else if (line_end) begin
            col_nxt  = '0;
            row_nxt  = row + ROW_W'(1);
            base_nxt = base_addr + ADDR_W'(3);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            base_addr <= '0;
            last      <= 1'b0;
        end else if (advance) begin
            col       <= col_nxt;
            row       <= row_nxt;
            base_addr <= base_nxt;
            last      <= (row_nxt == ROW_W'(IMG_H - 3)) && (col_nxt == COL_W'(IMG_W - 3));
        end
    end

endmodule

// File: rtl/conv3x3_window_assembler.sv
// Collects nine sequencer pixels into a 3x3 window and hands it downstream.
// Define CONV3X3_WINDOW_SUM_EN to add the out_sum window-sum output.
module conv3x3_window_assembler
    import conv3x3_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
) (
    input  logic                        clk,
    input  logic                        reset_n,
    conv3x3_window_assembler_if.slave   bus
);
    state_t           state, state_nxt;
    logic [3:0]       slot;
    logic [PIX_W-1:0] win [WIN_SLOTS];
    logic             accept, release_win, err_seq;

    assign bus.in_ready  = (state == COLLECT);
    assign bus.out_valid = (state == HOLD);
    assign bus.err_seq   = err_seq;
    assign accept        = bus.in_valid && bus.in_ready;
    assign release_win   = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= COLLECT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && slot == 4'(WIN_SLOTS - 1)) state_nxt = HOLD;
            HOLD:    if (release_win) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Pixels land by the local slot count; in_idx only feeds the order check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot    <= '0;
            err_seq <= 1'b0;
            for (int k = 0; k < WIN_SLOTS; k++) win[k] <= '0;
        end else if (accept) begin
            win[slot] <= bus.in_pix;
            slot      <= (slot == 4'(WIN_SLOTS - 1)) ? 4'd0 : slot + 4'd1;
            if (bus.in_idx != slot) err_seq <= 1'b1;
        end
    end

    for (genvar k = 0; k < WIN_SLOTS; k++) begin : g_pack
        assign bus.out_win[k*PIX_W +: PIX_W] = win[k];
    end

`ifdef CONV3X3_WINDOW_SUM_EN
    logic [PIX_W+3:0] sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         sum <= '0;
        else if (release_win) sum <= '0;
        else if (accept)      sum <= sum + {4'b0, bus.in_pix};
    end

    assign bus.out_sum = sum;
`endif

    conv3x3_pos_tracker #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance   (release_win),
        .base_addr (bus.out_base_addr),
        .last      (bus.out_last)
    );

endmodule

// File: tb/tb_conv3x3_window_assembler.sv
// Directed bench for conv3x3_window_assembler on a 640x4 frame (two window rows).
module tb_conv3x3_window_assembler;
    localparam int IMG_W  = 640;
    localparam int IMG_H  = 4;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 19;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    conv3x3_window_assembler_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    conv3x3_window_assembler #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic [31:0] slot_of(input int k);
        return 32'(bus.out_win[k*PIX_W +: PIX_W]);
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic push(input logic [3:0] idx, input logic [PIX_W-1:0] pix);
        bus.in_valid = 1'b1;
        bus.in_idx   = idx;
        bus.in_pix   = pix;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_window(input logic [PIX_W-1:0] pix, output logic [31:0] base,
                              output logic last, output logic vld);
        for (int k = 0; k < 9; k++) push(4'(k), pix);
        bus.in_valid = 1'b0;
        vld  = bus.out_valid;
        base = 32'(bus.out_base_addr);
        last = bus.out_last;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] base;
    logic        last, vld;
    logic [3:0]  bad_idx [9];

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_pix    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_win", 32'(bus.out_win != '0), 0);
        chk("rst_base", 32'(bus.out_base_addr), 0);
        chk("rst_last", 32'(bus.out_last), 0);
        chk("rst_err", 32'(bus.err_seq), 0);
        reset_n = 1'b1;

        // back-to-back window, downstream always ready
        bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) push(4'(k), PIX_W'(10 + k));
        bus.in_valid = 1'b0;
        chk("w0_valid", 32'(bus.out_valid), 1);
        chk("w0_in_ready", 32'(bus.in_ready), 0);
        chk("w0_slot0", slot_of(0), 10);
        chk("w0_slot4", slot_of(4), 14);
        chk("w0_slot8", slot_of(8), 18);
        chk("w0_base", 32'(bus.out_base_addr), 0);
        chk("w0_err", 32'(bus.err_seq), 0);
`ifdef CONV3X3_WINDOW_SUM_EN
        chk("w0_sum", 32'(bus.out_sum), 126);
`endif
        @(posedge clk);
        @(negedge clk);
        chk("w0_drop_valid", 32'(bus.out_valid), 0);
        chk("w0_in_ready_back", 32'(bus.in_ready), 1);

        // stalled downstream with stray in_valid pulses
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) push(4'(k), PIX_W'(20 + k));
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_slot0", slot_of(0), 20);
            chk("stall_slot8", slot_of(8), 28);
            chk("stall_base", 32'(bus.out_base_addr), 1);
            bus.in_valid = 1'b1;
            bus.in_idx   = 4'd0;
            bus.in_pix   = 8'd99;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stall_still_valid", 32'(bus.out_valid), 1);
        @(posedge clk);
        @(negedge clk);
        chk("release_valid", 32'(bus.out_valid), 0);
        chk("stray_not_stored", slot_of(0), 20);
        chk("stray_no_err", 32'(bus.err_seq), 0);

        // first window row, then line wrap
        for (int c = 2; c <= 637; c++) begin
            run_window(PIX_W'(c), base, last, vld);
            if (c == 637) begin
                chk("w637_base", base, 637);
                chk("w637_last", 32'(last), 0);
            end
        end
        run_window(8'h5a, base, last, vld);
        chk("w638_valid", 32'(vld), 1);
        chk("w638_base", base, 640);
        chk("w638_slot8", slot_of(8), 32'h5a);

        // rest of the final window row
        for (int c = 1; c <= 636; c++) run_window(PIX_W'(c), base, last, vld);
        chk("pre_final_last", 32'(last), 0);
        run_window(8'h11, base, last, vld);
        chk("final_base", base, 1277);
        chk("final_last", 32'(last), 1);
        run_window(8'h22, base, last, vld);
        chk("wrap_base", base, 0);
        chk("wrap_last", 32'(last), 0);

        // out-of-order slot index
        bad_idx = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8};
        for (int k = 0; k < 9; k++) begin
            push(bad_idx[k], PIX_W'(50 + k));
            if (k == 1) chk("err_before", 32'(bus.err_seq), 0);
            if (k == 2) chk("err_third", 32'(bus.err_seq), 1);
        end
        bus.in_valid = 1'b0;
        chk("err_win_valid", 32'(bus.out_valid), 1);
        chk("err_win_slot2", slot_of(2), 52);
        chk("err_win_base", 32'(bus.out_base_addr), 1);
        @(posedge clk);
        @(negedge clk);
        chk("err_sticky", 32'(bus.err_seq), 1);

        // reset in the middle of a window
        for (int k = 0; k < 4; k++) push(4'(k), PIX_W'(1 + k));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_slot0", slot_of(0), 0);
        chk("mid_rst_err", 32'(bus.err_seq), 0);
        chk("mid_rst_base", 32'(bus.out_base_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) push(4'(k), 8'd255);
        bus.in_valid = 1'b0;
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_slot0", slot_of(0), 255);
        chk("post_rst_slot3", slot_of(3), 255);
        chk("post_rst_slot8", slot_of(8), 255);
        chk("post_rst_base", 32'(bus.out_base_addr), 0);
        chk("post_rst_err", 32'(bus.err_seq), 0);
`ifdef CONV3X3_WINDOW_SUM_EN
        chk("post_rst_sum", 32'(bus.out_sum), 2295);
`endif
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_drop", 32'(bus.out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
